fact_accel_q: RTL and testbench

- Memory-mapped factorial accelerator slave that sits on the shared master bus next to the data memory.
- Replaces the single-operand factorial unit with a parametrised version:
  - configurable data width and operand width;
  - operand queue and result queue;
  - overflow detection with saturation;
  - batch processing of all queued operands from one start command.
- Raises a level interrupt when a batch completes.

---
 rtl/fact_accel_q.sv | 160 ++++++++++++++++
 tb/tb_fact_accel_q.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fact_accel_q.sv
// fact_accel_q: memory-mapped factorial accelerator with operand/result queues,
// saturating overflow detection, batch processing and a level interrupt.
module fact_accel_q #(
    parameter int DATA_WIDTH = 64,
    parameter int OP_WIDTH   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  s_sel,
    input  logic                  s_wr,
    input  logic [15:0]           s_addr,
    input  logic [DATA_WIDTH-1:0] s_din,
    output logic [DATA_WIDTH-1:0] s_dout,
    output logic                  interrupt
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, MULT, WRITE, DONE} state_t;

    state_t                  r_state, w_state_nx;
    logic [DATA_WIDTH-1:0]   r_acc;
    logic [OP_WIDTH-1:0]     r_cnt;
    logic                    r_ovf, r_done, r_any_ovf, r_err_push, r_intr_en;
    logic [OP_WIDTH-1:0]     r_op_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   r_res_mem [FIFO_DEPTH];
    logic [AW-1:0]           r_op_rd, r_op_wr, r_res_rd, r_res_wr;
    logic [AW:0]             r_op_cnt, r_res_cnt;

    logic [2:0]              w_idx;
    logic                    w_wr, w_start, w_clear, w_intr_wr, w_op_push, w_respop, w_go, w_busy;
    logic                    w_op_full, w_op_empty, w_res_full, w_res_empty;
    logic                    w_op_push_en, w_op_pop_en, w_res_push, w_res_pop_en, w_ovf_hi;
    logic [OP_WIDTH-1:0]     w_op_head;
    logic [DATA_WIDTH-1:0]   w_res_head;
    logic [2*DATA_WIDTH-1:0] w_prod;
    logic                    w_unused;

    assign w_idx     = s_addr[5:3];
    assign w_wr      = s_sel & s_wr;
    assign w_start   = w_wr && w_idx == 3'd0 && s_din[0];
    assign w_clear   = w_wr && w_idx == 3'd1 && s_din[0];
    assign w_intr_wr = w_wr && w_idx == 3'd3;
    assign w_op_push = w_wr && w_idx == 3'd4;
    assign w_respop  = w_wr && w_idx == 3'd7 && s_din[0];
    assign w_unused  = ^{s_addr[15:6], s_addr[2:0], s_din[DATA_WIDTH-1:OP_WIDTH]};

    assign w_op_full    = r_op_cnt == (AW+1)'(FIFO_DEPTH);
    assign w_op_empty   = r_op_cnt == '0;
    assign w_res_full   = r_res_cnt == (AW+1)'(FIFO_DEPTH);
    assign w_res_empty  = r_res_cnt == '0;
    assign w_op_head    = r_op_mem[r_op_rd];
    assign w_res_head   = r_res_mem[r_res_rd];
    assign w_op_pop_en  = r_state == LOAD && !w_op_empty;
    assign w_op_push_en = w_op_push && (!w_op_full || w_op_pop_en);
    assign w_res_pop_en = w_respop && !w_res_empty;
    assign w_res_push   = r_state == WRITE && (!w_res_full || w_res_pop_en);

    assign w_go     = w_start && !w_op_empty;
    assign w_busy   = r_state != IDLE && r_state != DONE;
    assign w_prod   = (2*DATA_WIDTH)'(r_acc) * (2*DATA_WIDTH)'(r_cnt);
    assign w_ovf_hi = |w_prod[2*DATA_WIDTH-1:DATA_WIDTH];

    assign interrupt = r_done & r_intr_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE, DONE: w_state_nx = w_go ? LOAD : r_state;
            LOAD:       w_state_nx = MULT;
            MULT:       w_state_nx = (w_ovf_hi || r_cnt <= OP_WIDTH'(2)) ? WRITE : MULT;
            WRITE:      w_state_nx = !w_res_push ? WRITE : (w_op_empty ? DONE : LOAD);
            default:    w_state_nx = IDLE;
        endcase
        if (w_clear) w_state_nx = IDLE;
    end

    // Operands 0 and 1 still take one MULT pass (cnt=1) so every result has the same max(N,2)+1 latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
            r_any_ovf  <= 1'b0;
            r_err_push <= 1'b0;
            r_intr_en  <= 1'b0;
        end else begin
            if (w_intr_wr) r_intr_en <= s_din[0];
            if (r_state == LOAD) begin
                r_acc <= DATA_WIDTH'(1);
                r_cnt <= (w_op_head < OP_WIDTH'(2)) ? OP_WIDTH'(1) : w_op_head;
                r_ovf <= 1'b0;
            end
            if (r_state == MULT) begin
                r_acc <= w_ovf_hi ? '1 : w_prod[DATA_WIDTH-1:0];
                r_cnt <= r_cnt - 1'b1;
                r_ovf <= r_ovf | w_ovf_hi;
            end
            if (w_clear) begin
                r_done     <= 1'b0;
                r_any_ovf  <= 1'b0;
                r_err_push <= 1'b0;
            end else begin
                if (w_op_push && !w_op_push_en) r_err_push <= 1'b1;
                if (w_res_push) r_any_ovf <= r_any_ovf | r_ovf;
                if (w_res_push && w_op_empty) r_done <= 1'b1;
                else if (w_go && r_state == DONE) r_done <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op_rd   <= '0;
            r_op_wr   <= '0;
            r_op_cnt  <= '0;
            r_res_rd  <= '0;
            r_res_wr  <= '0;
            r_res_cnt <= '0;
        end else if (w_clear) begin
            r_op_rd   <= '0;
            r_op_wr   <= '0;
            r_op_cnt  <= '0;
            r_res_rd  <= '0;
            r_res_wr  <= '0;
            r_res_cnt <= '0;
        end else begin
            r_op_wr   <= r_op_wr + AW'(w_op_push_en);
            r_op_rd   <= r_op_rd + AW'(w_op_pop_en);
            r_op_cnt  <= r_op_cnt + (AW+1)'(w_op_push_en) - (AW+1)'(w_op_pop_en);
            r_res_wr  <= r_res_wr + AW'(w_res_push);
            r_res_rd  <= r_res_rd + AW'(w_res_pop_en);
            r_res_cnt <= r_res_cnt + (AW+1)'(w_res_push) - (AW+1)'(w_res_pop_en);
        end
    end

    always_ff @(posedge clk) begin
        if (w_op_push_en) r_op_mem[r_op_wr] <= s_din[OP_WIDTH-1:0];
        if (w_res_push) r_res_mem[r_res_wr] <= r_acc;
    end

    always_comb begin
        s_dout = '0;
        if (s_sel) begin
            case (w_idx)
                3'd2:    s_dout[3:0] = {r_err_push, r_any_ovf, w_busy, r_done};
                3'd3:    s_dout[0] = r_intr_en;
                3'd5:    s_dout[17:0] = {w_res_empty, w_op_full, 8'(r_res_cnt), 8'(r_op_cnt)};
                3'd6:    s_dout = w_res_empty ? '0 : w_res_head;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fact_accel_q.sv
// tb_fact_accel_q: directed and randomized checks of fact_accel_q against a
// plain-arithmetic factorial model.
module tb_fact_accel_q;
    localparam int OPSTART = 0, OPCLEAR = 1, OPDONE = 2, INTREN = 3;
    localparam int OPERAND = 4, STATUS = 5, RESULT = 6, RESPOP = 7;

    logic        clk = 1'b0, reset_n = 1'b0, s_sel = 1'b0, s_wr = 1'b0;
    logic [15:0] s_addr = '0;
    logic [63:0] s_din = '0, s_dout;
    logic        interrupt;
    int          checks = 0, failures = 0, irq_rises = 0;
    logic [63:0] d;
    logic [64:0] m;
    logic [63:0] exp_q[$];
    logic        exp_ovf;

    fact_accel_q dut (
        .clk(clk), .reset_n(reset_n), .s_sel(s_sel), .s_wr(s_wr),
        .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout), .interrupt(interrupt)
    );

    always #5 clk = ~clk;
    always @(posedge interrupt) irq_rises++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // {overflow, saturated value} of n! computed in ascending order
    function automatic logic [64:0] fact(input int n);
        logic [127:0] p;
        p = 128'd1;
        for (int i = 2; i <= n; i++) begin
            p = p * 128'(i);
            if (p[127:64] != 0) return {1'b1, {64{1'b1}}};
        end
        return {1'b0, p[63:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input int idx, input logic [63:0] v);
        s_sel = 1'b1; s_wr = 1'b1; s_addr = 16'(idx * 8); s_din = v;
        @(negedge clk);
        s_sel = 1'b0; s_wr = 1'b0; s_din = '0;
    endtask

    task automatic rd(input int idx, output logic [63:0] v);
        s_sel = 1'b1; s_wr = 1'b0; s_addr = 16'(idx * 8);
        #1 v = s_dout;
        s_sel = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        logic [63:0] v;
        int n = 0;
        rd(OPDONE, v);
        while (!v[0] && n < budget) begin
            @(negedge clk);
            rd(OPDONE, v);
            n++;
        end
        chk("done_within_budget", 64'(v[0]), 64'd1);
    endtask

    initial begin
        #2;
        chk("rst_irq", 64'(interrupt), 64'd0);
        chk("rst_dout_idle", s_dout, 64'd0);
        rd(OPDONE, d); chk("rst_opdone", d, 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rd(STATUS, d); chk("rst_status", d, 64'h20000);

        // single operand, cycle-exact latency
        wr(INTREN, 1); wr(OPERAND, 5); wr(OPSTART, 1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            rd(STATUS, d); chk($sformatf("lat5_k%0d", k), 64'(d[15:8]), 64'(k >= 6));
        end
        rd(RESULT, d); chk("fact5", d, 64'd120);
        rd(OPDONE, d); chk("t1_opdone", d, 64'd1);
        chk("t1_irq", 64'(interrupt), 64'd1);
        wr(OPCLEAR, 1);
        chk("t1_irq_clr", 64'(interrupt), 64'd0);
        rd(STATUS, d); chk("t1_status_clr", d, 64'h20000);
        rd(INTREN, d); chk("t1_intren_kept", d, 64'd1);

        // batch of three, one done rise
        irq_rises = 0;
        wr(OPERAND, 5); wr(OPERAND, 10); wr(OPERAND, 3); wr(OPSTART, 1);
        wait_done(100);
        rd(STATUS, d); chk("t2_rescount", 64'(d[15:8]), 64'd3);
        exp_q = '{64'd120, 64'd3628800, 64'd6};
        while (exp_q.size() > 0) begin
            rd(RESULT, d); chk("t2_result", d, exp_q.pop_front());
            wr(RESPOP, 1);
        end
        chk("t2_single_done", 64'(irq_rises), 64'd1);
        rd(STATUS, d); chk("t2_res_empty", 64'(d[17]), 64'd1);
        wr(OPCLEAR, 1);

        // overflow boundary 21! vs 20!
        wr(OPERAND, 21); wr(OPSTART, 1); wait_done(100);
        rd(RESULT, d); chk("fact21_sat", d, {64{1'b1}});
        rd(OPDONE, d); chk("fact21_opdone", d, 64'h5);
        wr(OPCLEAR, 1);
        wr(OPERAND, 20); wr(OPSTART, 1); wait_done(100);
        rd(RESULT, d); chk("fact20", d, 64'd2432902008176640000);
        rd(OPDONE, d); chk("fact20_opdone", d, 64'h1);
        wr(OPCLEAR, 1);

        // operands 0 and 1: push at E0+3 and E0+6
        wr(OPERAND, 0); wr(OPERAND, 1); wr(OPSTART, 1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            rd(STATUS, d);
            chk($sformatf("lat01_k%0d", k), 64'(d[15:8]), (k >= 6) ? 64'd2 : (k >= 3) ? 64'd1 : 64'd0);
        end
        rd(OPDONE, d); chk("t4_done", d, 64'd1);
        rd(RESULT, d); chk("fact0", d, 64'd1);
        wr(RESPOP, 1);
        rd(RESULT, d); chk("fact1", d, 64'd1);
        wr(OPCLEAR, 1);

        // operand overflow, then result-FIFO stall
        for (int i = 0; i < 5; i++) wr(OPERAND, 3);
        rd(STATUS, d); chk("t5_opcount", 64'(d[7:0]), 64'd4); chk("t5_opfull", 64'(d[16]), 64'd1);
        rd(OPDONE, d); chk("t5_err_push", 64'(d[3]), 64'd1);
        wr(OPSTART, 1);
        wr(OPERAND, 4);
        rd(STATUS, d); chk("t5_push_pop_full", 64'(d[7:0]), 64'd4);
        repeat (40) @(negedge clk);
        rd(OPDONE, d); chk("t5_stall_opdone", d, 64'hA);
        rd(STATUS, d); chk("t5_stall_status", d, 64'h0400);
        rd(RESULT, d); chk("t5_head", d, 64'd6);
        wr(RESPOP, 1);
        rd(OPDONE, d); chk("t5_release", d, 64'h9);
        rd(STATUS, d); chk("t5_rescount_after", 64'(d[15:8]), 64'd4);
        exp_q = '{64'd6, 64'd6, 64'd6, 64'd24};
        while (exp_q.size() > 0) begin
            rd(RESULT, d); chk("t5_result", d, exp_q.pop_front());
            wr(RESPOP, 1);
        end
        rd(STATUS, d); chk("t5_res_empty", 64'(d[17]), 64'd1);

        // randomized batches vs model
        for (int r = 0; r < 6; r++) begin
            int n, op;
            wr(OPCLEAR, 1);
            n = $urandom_range(1, 4);
            exp_ovf = 1'b0;
            exp_q.delete();
            for (int i = 0; i < n; i++) begin
                op = $urandom_range(0, 24);
                m = fact(op);
                exp_q.push_back(m[63:0]);
                exp_ovf |= m[64];
                wr(OPERAND, 64'(op));
            end
            wr(OPSTART, 1);
            wait_done(200);
            rd(OPDONE, d); chk($sformatf("rnd%0d_opdone", r), d, exp_ovf ? 64'h5 : 64'h1);
            while (exp_q.size() > 0) begin
                rd(RESULT, d); chk($sformatf("rnd%0d_result", r), d, exp_q.pop_front());
                wr(RESPOP, 1);
            end
            rd(STATUS, d); chk($sformatf("rnd%0d_empty", r), d, 64'h20000);
        end

        // abort in flight
        wr(OPCLEAR, 1);
        wr(OPERAND, 10); wr(OPSTART, 1);
        repeat (3) @(negedge clk);
        rd(OPDONE, d); chk("t7_busy", d, 64'h2);
        wr(OPCLEAR, 1);
        rd(OPDONE, d); chk("t7_opdone", d, 64'd0);
        rd(STATUS, d); chk("t7_status", d, 64'h20000);
        repeat (15) @(negedge clk);
        rd(STATUS, d); chk("t7_no_late_push", d, 64'h20000);

        // asynchronous reset mid-batch
        wr(OPERAND, 10); wr(OPSTART, 1);
        @(negedge clk);
        rd(OPDONE, d); chk("t8_busy", d, 64'h2);
        reset_n = 1'b0;
        #1;
        chk("t8_irq", 64'(interrupt), 64'd0);
        chk("t8_dout_idle", s_dout, 64'd0);
        rd(OPDONE, d); chk("t8_opdone", d, 64'd0);
        rd(INTREN, d); chk("t8_intren", d, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
